// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sd_pkg
//  Brief    : Constants shared by the SD data-line engine and its FIFOs.
//  Revision : 1.0  initial release
// ============================================================================
package sd_pkg;

    // Width of one data-path word.
    localparam int SD_WORD_W          = 32;
    // Default log2 of the FIFO word capacity (256 words).
    localparam int SD_FIFO_DEPTH_BITS = 8;

    typedef logic [SD_WORD_W-1:0] sd_word_t;

endpackage : sd_pkg
`default_nettype wire

// File: rtl/sd_dat_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : sd_dat_fifo_ram
//  Brief    : 2**ADDR_W x DATA_W storage for the SD data FIFO. Synchronous
//             write, asynchronous read, so it maps onto LUT RAM and can be
//             swapped for a vendor macro without touching pointer logic.
//  Revision : 1.0  initial release
// ============================================================================
module sd_dat_fifo_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Store the accepted word; storage itself is not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Head word is read combinationally for first-word-fall-through.
    assign o_rdata = r_mem[i_raddr];

endmodule : sd_dat_fifo_ram
`default_nettype wire

// File: rtl/sd_dat_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sd_dat_fifo
//  Brief    : 32-bit first-word-fall-through FIFO for the SD data path with
//             registered item count and sticky overrun/underrun flags.
//             Optional registered watermark comparator when the macro
//             SD_DAT_FIFO_WATERMARK_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module sd_dat_fifo
    import sd_pkg::*;
#(
    parameter int DEPTH_BITS = SD_FIFO_DEPTH_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [SD_WORD_W-1:0]  i_data,
    input  logic                  i_pop,
    output logic [SD_WORD_W-1:0]  o_data,
    output logic [DEPTH_BITS:0]   o_items,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_overrun,
`ifdef SD_DAT_FIFO_WATERMARK_EN
    input  logic [DEPTH_BITS:0]   i_watermark,
    output logic                  o_watermark,
`endif
    output logic                  o_underrun
);

    localparam logic [DEPTH_BITS:0]   c_cap      = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [DEPTH_BITS:0]   c_cnt_one  = {{DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [DEPTH_BITS-1:0] c_ptr_one  = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_overrun;
    logic                  r_underrun;

    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [DEPTH_BITS:0]   w_count_next;
    logic                  w_clear;

    assign w_clear = i_reset | i_flush;

    // Acceptance decisions use only registered status. A full FIFO still
    // takes a push when a pop frees the head slot in the same cycle.
    assign w_pop_ok  = i_pop  & ~r_empty;
    assign w_push_ok = i_push & (~r_full | i_pop);

    // Next count: +1, -1 or hold; a simultaneous push and pop cancel.
    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + c_cnt_one;
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_next = r_count - c_cnt_one;
        end
    end

    // Pointers, count, registered status and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == c_cap);
            if (i_push && r_full && !i_pop) begin
                r_overrun <= 1'b1;
            end
            if (i_pop && r_empty) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // Storage; a write while flushing is suppressed so nothing is committed.
    sd_dat_fifo_ram #(
        .ADDR_W (DEPTH_BITS),
        .DATA_W (SD_WORD_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_push_ok & ~w_clear),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (o_data)
    );

`ifdef SD_DAT_FIFO_WATERMARK_EN
    logic r_watermark;

    // Level compare against the registered count, so it trails o_items by one cycle.
    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_watermark <= 1'b0;
        end else begin
            r_watermark <= (r_count >= i_watermark);
        end
    end

    assign o_watermark = r_watermark;
`endif

    assign o_items    = r_count;
    assign o_empty    = r_empty;
    assign o_full     = r_full;
    assign o_overrun  = r_overrun;
    assign o_underrun = r_underrun;

endmodule : sd_dat_fifo
`default_nettype wire

// File: tb/tb_sd_dat_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_dat_fifo
//  Brief    : Self-checking bench for sd_dat_fifo against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sd_dat_fifo;

    localparam int DB  = 8;
    localparam int CAP = 1 << DB;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_flush;
    logic          i_push;
    logic [31:0]   i_data;
    logic          i_pop;
    logic [31:0]   o_data;
    logic [DB:0]   o_items;
    logic          o_empty;
    logic          o_full;
    logic          o_overrun;
    logic          o_underrun;
`ifdef SD_DAT_FIFO_WATERMARK_EN
    logic [DB:0]   i_watermark;
    logic          o_watermark;
`endif

    sd_dat_fifo #(.DEPTH_BITS(DB)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flush     (i_flush),
        .i_push      (i_push),
        .i_data      (i_data),
        .i_pop       (i_pop),
        .o_data      (o_data),
        .o_items     (o_items),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_overrun   (o_overrun),
`ifdef SD_DAT_FIFO_WATERMARK_EN
        .i_watermark (i_watermark),
        .o_watermark (o_watermark),
`endif
        .o_underrun  (o_underrun)
    );

    always #5 i_clk = ~i_clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model state
    logic [31:0] m_q[$];
    bit          m_ovr;
    bit          m_udr;
    bit          m_wm;
    int          m_wm_thr;
    logic [31:0] last_pop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one clock cycle of stimulus, advance the model, and compare.
    task automatic cyc(input bit push, input bit pop, input bit flush, input logic [31:0] d);
        int sz;
        bit full, empty;
        i_push  = push;
        i_pop   = pop;
        i_flush = flush;
        i_data  = d;
        sz    = m_q.size();
        full  = (sz == CAP);
        empty = (sz == 0);
        @(posedge i_clk);
        if (flush) begin
            m_q.delete();
            m_ovr = 0;
            m_udr = 0;
            m_wm  = 0;
        end else begin
            m_wm = (sz >= m_wm_thr);
            if (pop && !empty) last_pop = m_q.pop_front();
            if (push && (!full || pop)) m_q.push_back(d);
            if (push && full && !pop) m_ovr = 1;
            if (pop && empty) m_udr = 1;
        end
        #1;
        check("items",    32'(o_items),    32'(m_q.size()));
        check("empty",    32'(o_empty),    32'(m_q.size() == 0));
        check("full",     32'(o_full),     32'(m_q.size() == CAP));
        check("overrun",  32'(o_overrun),  32'(m_ovr));
        check("underrun", 32'(o_underrun), 32'(m_udr));
        if (m_q.size() != 0) check("head", o_data, m_q[0]);
`ifdef SD_DAT_FIFO_WATERMARK_EN
        check("watermark", 32'(o_watermark), 32'(m_wm));
`endif
    endtask

    task automatic idle();
        cyc(0, 0, 0, 32'h0);
    endtask

    initial begin
        m_ovr = 0; m_udr = 0; m_wm = 0; m_wm_thr = CAP + 1; last_pop = '0;
        i_reset = 1'b1; i_flush = 0; i_push = 0; i_pop = 0; i_data = '0;
`ifdef SD_DAT_FIFO_WATERMARK_EN
        i_watermark = (DB+1)'(CAP); // out of reach of the model's default threshold handling below
        m_wm_thr    = CAP;
`endif
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        check("rst_items", 32'(o_items), 32'd0);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_full",  32'(o_full),  32'd0);
        check("rst_ovr",   32'(o_overrun),  32'd0);
        check("rst_udr",   32'(o_underrun), 32'd0);

        // 1: three pushes, three pops
        for (int k = 1; k <= 3; k++) cyc(1, 0, 0, 32'hA5A5_0000 + 32'(k));
        check("t1_items", 32'(o_items), 32'd3);
        check("t1_head",  o_data, 32'hA5A5_0001);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 32'h0);
        check("t1_empty", 32'(o_empty), 32'd1);
        check("t1_flags", 32'({o_overrun, o_underrun}), 32'd0);

        // 2: fill, extra push dropped, drain
        for (int k = 0; k < CAP; k++) cyc(1, 0, 0, 32'h2000_0000 + 32'(k));
        cyc(1, 0, 0, 32'hDEAD_BEEF);
        check("t2_full",  32'(o_full),     32'd1);
        check("t2_ovr",   32'(o_overrun),  32'd1);
        check("t2_items", 32'(o_items),    32'(CAP));
        for (int k = 0; k < CAP; k++) begin
            cyc(0, 1, 0, 32'h0);
            check("t2_data", last_pop, 32'h2000_0000 + 32'(k));
        end

        // 3: full FIFO, push with pop
        cyc(0, 0, 1, 32'h0);
        for (int k = 0; k < CAP; k++) cyc(1, 0, 0, 32'h3000_0000 + 32'(k));
        cyc(1, 1, 0, 32'h1234_5678);
        check("t3_items", 32'(o_items),   32'(CAP));
        check("t3_ovr",   32'(o_overrun), 32'd0);
        for (int k = 0; k < CAP; k++) cyc(0, 1, 0, 32'h0);
        check("t3_last",  last_pop, 32'h1234_5678);

        // 4: empty FIFO, push with pop (write-through)
        cyc(1, 1, 0, 32'hCAFE_0000);
        check("t4_items", 32'(o_items),    32'd1);
        check("t4_udr",   32'(o_underrun), 32'd1);
        check("t4_data",  o_data,          32'hCAFE_0000);

        // 5: 100 words with both flags, then flush with push
        cyc(0, 0, 1, 32'h0);
        cyc(0, 1, 0, 32'h0);
        for (int k = 0; k < CAP; k++) cyc(1, 0, 0, $urandom);
        cyc(1, 0, 0, 32'h5555_5555);
        for (int k = 0; k < CAP - 100; k++) cyc(0, 1, 0, 32'h0);
        check("t5_pre", 32'({o_overrun, o_underrun, 23'(o_items)}), {2'b11, 23'd100});
        cyc(1, 0, 1, 32'h7777_7777);
        check("t5_items", 32'(o_items), 32'd0);
        check("t5_empty", 32'(o_empty), 32'd1);
        check("t5_flags", 32'({o_overrun, o_underrun}), 32'd0);

`ifdef SD_DAT_FIFO_WATERMARK_EN
        // 6: watermark at 129
        i_watermark = 9'd129;
        m_wm_thr    = 129;
        cyc(0, 0, 1, 32'h0);
        for (int k = 0; k < 129; k++) cyc(1, 0, 0, 32'h6000_0000 + 32'(k));
        check("t6_lag",  32'(o_watermark), 32'd0);
        idle();
        check("t6_rise", 32'(o_watermark), 32'd1);
        cyc(0, 1, 0, 32'h0);
        check("t6_hold", 32'(o_watermark), 32'd1);
        idle();
        check("t6_fall", 32'(o_watermark), 32'd0);
        cyc(0, 0, 1, 32'h0);
`endif

        // Randomized traffic with phases biased toward filling and draining.
        for (int ph = 0; ph < 8; ph++) begin
            int pp;
            pp = (ph % 2 == 0) ? 80 : 20;
            for (int k = 0; k < 500; k++) begin
                bit pu, po, fl;
                pu = ($urandom_range(99) < pp);
                po = ($urandom_range(99) < 100 - pp);
                fl = ($urandom_range(999) == 0);
                cyc(pu, po, fl, $urandom);
            end
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sd_dat_fifo
`default_nettype wire
